uart_rx: RTL and testbench

Serial receiver for one UART frame. It is the downstream counterpart of the transmitter and decodes the `dataOut` line that the transmitter drives. Each frame is a low start bit, `dataLen` data bits sent LSB first, an optional even-XOR parity bit and 1 or 2 high stop bits. The block deserialises the frame, checks it and presents the word with a one-cycle valid strobe to the consuming logic.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_rx_sync.sv | 43 ++++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity type and the log2 helper
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int PAR_XOR = 0;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, decoded word plus status out.
interface uart_rx_if #(
  parameter int dataLen = 8
);
  logic               dataIn;
  logic [dataLen-1:0] data;
  logic               valid;
  logic               parErr;
  logic               frameErr;
  logic               busy;

  modport master (input dataIn, output data, valid, parErr, frameErr, busy);
  modport slave  (output dataIn, input data, valid, parErr, frameErr, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer with falling-edge detect for the serial line.
// UART_RX_MAJORITY_EN adds a 2-of-3 majority over the last three synchronized samples.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rxs,
  output logic fall,
  output logic smp
);

  logic s1;
  logic rxs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      s1    <= din;
      rxs   <= s1;
      rxs_d <= rxs;
    end
  end

  assign fall = rxs_d & ~rxs;

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rxs_d2 <= 1'b1;
    else     rxs_d2 <= rxs_d;
  end

  // Taps are rxs now, one and two clocks ago.
  assign smp = (rxs & rxs_d) | (rxs & rxs_d2) | (rxs_d & rxs_d2);
`else
  assign smp = rxs;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART frame receiver: start, dataLen bits LSB first, optional parity, 1-2 stops.
// UART_RX_MAJORITY_EN selects 3-sample majority voting (decisions one clock later).
module uart_rx
  import uart_pkg::*;
#(
  parameter int T          = 9600,
  parameter int F_clk_Gz   = 100_000_000,
  parameter int par        = 0,
  parameter int stop       = 1,
  parameter int dataLen    = 8,
  parameter int BIT_CYCLES = F_clk_Gz / T
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int TW       = log2(BIT_CYCLES) + 1;
  localparam int PAR_TYPE = PAR_XOR;
`ifdef UART_RX_MAJORITY_EN
  localparam int SLIP = 1;
`else
  localparam int SLIP = 0;
`endif

  // With voting the decision lands one clock late, so the timer restarts at
  // SLIP to keep the bit period exactly BIT_CYCLES.
  localparam logic [TW-1:0] HALF_AT   = TW'(BIT_CYCLES / 2 - 1 + SLIP);
  localparam logic [TW-1:0] FULL_AT   = TW'(BIT_CYCLES - 1 + SLIP);
  localparam logic [TW-1:0] RELOAD    = TW'(SLIP);
  localparam logic [3:0]    LAST_BIT  = 4'(dataLen - 1);
  localparam logic [3:0]    LAST_STOP = 4'(stop - 1);

  logic rxs;
  logic fall;
  logic smp;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.dataIn),
    .rxs  (rxs),
    .fall (fall),
    .smp  (smp)
  );

  rx_state_t          state;
  logic [TW-1:0]      timer;
  logic [3:0]         cnt;
  logic [dataLen-1:0] sr;
  logic [dataLen-1:0] data_reg;
  logic               perr_acc;
  logic               ferr_acc;
  logic               fin_reg;
  logic               valid_reg;
  logic               perr_reg;
  logic               ferr_reg;
  logic               busy_reg;
  logic               par_bit;

  assign par_bit = (PAR_TYPE == PAR_XOR) ? ^sr : ~(^sr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      sr        <= '0;
      data_reg  <= '0;
      perr_acc  <= 1'b0;
      ferr_acc  <= 1'b0;
      fin_reg   <= 1'b0;
      valid_reg <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      // Publish one clock after the last stop sample, whatever state follows.
      if (fin_reg) begin
        fin_reg   <= 1'b0;
        valid_reg <= 1'b1;
        data_reg  <= sr;
        perr_reg  <= perr_acc;
        ferr_reg  <= ferr_acc;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state    <= START;
            busy_reg <= 1'b1;
            timer    <= '0;
          end
        end

        START: begin
          if (timer == HALF_AT) begin
            if (smp) begin
              state    <= IDLE;
              busy_reg <= 1'b0;
            end else begin
              state    <= DATA;
              timer    <= RELOAD;
              cnt      <= '0;
              perr_acc <= 1'b0;
              ferr_acc <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (timer == FULL_AT) begin
            sr    <= {smp, sr[dataLen-1:1]};
            timer <= RELOAD;
            cnt   <= cnt + 4'd1;
            if (cnt == LAST_BIT) begin
              cnt   <= '0;
              state <= (par != 0) ? PARITY : STOP;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        PARITY: begin
          if (timer == FULL_AT) begin
            perr_acc <= (smp != par_bit);
            timer    <= RELOAD;
            state    <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STOP: begin
          if (timer == FULL_AT) begin
            timer    <= RELOAD;
            cnt      <= cnt + 4'd1;
            ferr_acc <= ferr_acc | ~smp;
            if (cnt == LAST_STOP) begin
              fin_reg  <= 1'b1;
              state    <= smp ? IDLE : BREAK;
              busy_reg <= ~smp;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        BREAK: begin
          if (rxs) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data     = data_reg;
  assign bus.valid    = valid_reg;
  assign bus.parErr   = perr_reg;
  assign bus.frameErr = ferr_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three configurations (8N1, 8E1, 6-bit parity with 2 stops)
// driven by a bit-list frame builder whose own decode of the list is the reference.
module tb_uart_rx;

  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] line;

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_double = 0;

  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];
  logic [2:0]  vprev = 3'b000;

  always #5 clk = ~clk;

  uart_rx_if #(.dataLen(8)) if0 ();
  uart_rx_if #(.dataLen(8)) if1 ();
  uart_rx_if #(.dataLen(6)) if2 ();

  assign if0.dataIn = line[0];
  assign if1.dataIn = line[1];
  assign if2.dataIn = line[2];

  uart_rx #(.T(10_000_000), .F_clk_Gz(100_000_000), .par(0), .stop(1), .dataLen(8))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  uart_rx #(.T(10_000_000), .F_clk_Gz(100_000_000), .par(1), .stop(1), .dataLen(8))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_rx #(.T(10_000_000), .F_clk_Gz(100_000_000), .par(1), .stop(2), .dataLen(6))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Capture every valid pulse tagged with its unit number.
  always @(negedge clk) begin
    if (if0.valid) got_q.push_back({2'd0, if0.frameErr, if0.parErr, 9'(if0.data)});
    if (if1.valid) got_q.push_back({2'd1, if1.frameErr, if1.parErr, 9'(if1.data)});
    if (if2.valid) got_q.push_back({2'd2, if2.frameErr, if2.parErr, 9'(if2.data)});
    if ((if0.valid && vprev[0]) || (if1.valid && vprev[1]) || (if2.valid && vprev[2]))
      n_double++;
    vprev = {if2.valid, if1.valid, if0.valid};
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic drive(input int w, input logic lvl, input int cyc);
    line[w] = lvl;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // pmode: -1 no parity bit, 0 correct parity, 1 inverted parity.
  task automatic send(input int w, input int n, input logic [8:0] val, input int pmode,
                      input int nstop, input logic [1:0] stop_low, input int stop_extra);
    logic       bits[$];
    logic [8:0] d;
    logic       p;
    logic       pe;
    logic       fe;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) bits.push_back(val[i]);
    if (pmode >= 0) begin
      p = 1'b0;
      for (int i = 0; i < n; i++) p ^= val[i];
      bits.push_back(p ^ (pmode == 1));
    end
    for (int s = 0; s < nstop; s++) bits.push_back(~stop_low[s]);
    // Decode the list as a receiver would: data bits, even-XOR check, stop bits.
    d = '0;
    for (int i = 0; i < n; i++) d[i] = bits[1 + i];
    pe = 1'b0;
    if (pmode >= 0) begin
      p = bits[1 + n];
      for (int i = 0; i < n; i++) p ^= d[i];
      pe = p;
    end
    fe = 1'b0;
    for (int s = 0; s < nstop; s++) if (!bits[bits.size() - nstop + s]) fe = 1'b1;
    exp_q.push_back({w[1:0], fe, pe, d});
    for (int i = 0; i < bits.size(); i++)
      drive(w, bits[i], BC + ((i == bits.size() - 1) ? stop_extra : 0));
  endtask

  task automatic check_next(input string tag);
    logic [12:0] g;
    logic [12:0] e;
    int waited;
    waited = 0;
    while (got_q.size() == 0 && waited < 60) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk({tag, "_valid"}, 32'(got_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'h1fff;
    if (got_q.size() != 0) begin
      g = got_q.pop_front();
      $display("rx %s: unit %0d data %0h parErr %0b frameErr %0b", tag, g[12:11], g[8:0], g[9], g[10]);
      chk({tag, "_unit"},     32'(g[12:11]), 32'(e[12:11]));
      chk({tag, "_data"},     32'(g[8:0]),   32'(e[8:0]));
      chk({tag, "_parErr"},   32'(g[9]),     32'(e[9]));
      chk({tag, "_frameErr"}, 32'(g[10]),    32'(e[10]));
    end
  endtask

  initial begin
    logic [8:0] v;
    logic [8:0] keep;
    int         gap;
    int         pm;
    logic [1:0] sl;

    rst  = 1'b1;
    line = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data0",     32'(if0.data),     32'd0);
    chk("rst_valid0",    32'(if0.valid),    32'd0);
    chk("rst_parErr0",   32'(if0.parErr),   32'd0);
    chk("rst_frameErr0", 32'(if0.frameErr), 32'd0);
    chk("rst_busy0",     32'(if0.busy),     32'd0);
    chk("rst_busy1",     32'(if1.busy),     32'd0);
    chk("rst_busy2",     32'(if2.busy),     32'd0);
    rst = 1'b0;
    drive(0, 1'b1, 5);

    send(0, 8, 9'h0A5, -1, 1, 2'b00, 0);
    check_next("a5");
    chk("a5_busy", 32'(if0.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      v   = 9'($urandom_range(0, 255));
      gap = $urandom_range(0, 6);
      send(0, 8, v, -1, 1, 2'b00, 0);
      drive(0, 1'b1, gap);
      check_next("rand8n1");
    end

    // Stop bit low, line then held low: BREAK until the line recovers.
    v = 9'($urandom_range(0, 255));
    send(0, 8, v, -1, 1, 2'b01, 0);
    drive(0, 1'b0, 50);
    check_next("brk");
    chk("brk_busy_low", 32'(if0.busy), 32'd1);
    drive(0, 1'b1, 5);
    chk("brk_busy_idle", 32'(if0.busy), 32'd0);
    drive(0, 1'b1, 30);
    chk("brk_no_second_valid", 32'(got_q.size()), 32'd0);
    keep = v;

    drive(0, 1'b0, 3);
    drive(0, 1'b1, 40);
    chk("glitch_no_valid", 32'(got_q.size()), 32'd0);
    chk("glitch_data_kept", 32'(if0.data), 32'(keep[7:0]));
    chk("glitch_busy", 32'(if0.busy), 32'd0);

    // Back-to-back frames; the transmitter stretches each stop bit by 3 clocks.
    send(0, 8, 9'h001, -1, 1, 2'b00, 3);
    send(0, 8, 9'h0FE, -1, 1, 2'b00, 3);
    check_next("b2b_01");
    check_next("b2b_fe");

    send(1, 8, 9'h03C, 0, 1, 2'b00, 0);
    check_next("par_3c_ok");
    drive(1, 1'b1, 4);
    send(1, 8, 9'h03C, 1, 1, 2'b00, 0);
    check_next("par_3c_bad");
    for (int i = 0; i < 6; i++) begin
      v  = 9'($urandom_range(0, 255));
      pm = $urandom_range(0, 1);
      send(1, 8, v, pm, 1, 2'b00, 0);
      drive(1, 1'b1, $urandom_range(0, 4));
      check_next("rand8e1");
    end

    for (int i = 0; i < 8; i++) begin
      v  = 9'($urandom_range(0, 63));
      pm = $urandom_range(0, 1);
      sl = 2'($urandom_range(0, 3));
      send(2, 6, v, pm, 2, sl, 0);
      drive(2, 1'b1, 3 + $urandom_range(0, 4));
      check_next("rand6p2");
    end

    // Reset during data bit 4 (chosen high so release sees an idle line).
    v = 9'($urandom_range(0, 255)) | 9'h010;
    drive(0, 1'b0, BC);
    for (int i = 0; i < 4; i++) drive(0, v[i], BC);
    drive(0, v[4], 5);
    chk("midrst_busy_before", 32'(if0.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_data",     32'(if0.data),     32'd0);
    chk("midrst_valid",    32'(if0.valid),    32'd0);
    chk("midrst_parErr",   32'(if0.parErr),   32'd0);
    chk("midrst_frameErr", 32'(if0.frameErr), 32'd0);
    chk("midrst_busy",     32'(if0.busy),     32'd0);
    rst = 1'b0;
    drive(0, 1'b1, 40);
    chk("midrst_no_valid", 32'(got_q.size()), 32'd0);
    send(0, 8, 9'h055, -1, 1, 2'b00, 0);
    check_next("after_rst_55");

    chk("valid_single_cycle", 32'(n_double), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
